reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - reset request sequencer producing DCLO/ACLO to the CPU
// Optional ACLO-before-DCLO lead phase: define RESET_SEQUENCER_PFAIL_EN.
module reset_sequencer #(
  parameter int N_SRC       = 4,
  parameter int DCLO_CLK    = 24,
  parameter int ACLO_CLK    = 240,
  parameter int PFAIL_CLK   = 8,
  parameter int COLD_CLK    = 3000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] req_mask,
  output logic             dclo,
  output logic             aclo,
  output logic             cold_start,
  output logic [N_SRC-1:0] cause,
  output logic             busy
);

  localparam int DW = $clog2(DCLO_CLK + 1);
  localparam int AW = $clog2(ACLO_CLK + 1);
  localparam int HW = $clog2(COLD_CLK + 1);

  localparam logic [DW-1:0] DCLO_LAST = DW'(DCLO_CLK - 1);
  localparam logic [AW-1:0] ACLO_LAST = AW'(ACLO_CLK - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(COLD_CLK);

  if (N_SRC < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DCLO_CLK < 1 || DCLO_CLK > 65535 || ACLO_CLK < 1 || ACLO_CLK > 65535 ||
      PFAIL_CLK < 1 || PFAIL_CLK > 255 || COLD_CLK < 1) begin : g_param_check
    $error("reset_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_RUN,
    S_PFAIL,
    S_HOLD,
    S_DCLO,
    S_ACLO
  } state_t;

  state_t          state_q, state_d;
  logic            dclo_q, dclo_d;
  logic            aclo_q, aclo_d;
  logic            busy_q, busy_d;
  logic            cold_q, cold_d;
  logic [N_SRC-1:0] cause_q, cause_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_d [SYNC_STAGES];

`ifdef RESET_SEQUENCER_PFAIL_EN
  localparam int PW = $clog2(PFAIL_CLK + 1);
  localparam logic [PW-1:0] PFAIL_LAST = PW'(PFAIL_CLK - 1);
  logic [PW-1:0] pcnt_q, pcnt_d;
`endif

  logic [N_SRC-1:0] active_vec;
  logic             active;

  always_comb begin
    sync_d[0] = req;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Masking acts on the synchronised value, so a masked source drops out immediately.
  assign active_vec = sync_q[SYNC_STAGES-1] & ~req_mask;
  assign active     = |active_vec;

  always_comb begin
    state_d = state_q;
    dclo_d  = dclo_q;
    aclo_d  = aclo_q;
    cold_d  = cold_q;
    cause_d = cause_q;
    dcnt_d  = dcnt_q;
    acnt_d  = acnt_q;
    hcnt_d  = hcnt_q;
`ifdef RESET_SEQUENCER_PFAIL_EN
    pcnt_d  = pcnt_q;
`endif
    case (state_q)
      S_RUN: begin
        if (active) begin
          cause_d = active_vec;
`ifdef RESET_SEQUENCER_PFAIL_EN
          state_d = S_PFAIL;
          pcnt_d  = '0;
          aclo_d  = 1'b1;
`else
          state_d = S_HOLD;
          hcnt_d  = '0;
          dclo_d  = 1'b1;
          aclo_d  = 1'b1;
`endif
        end
      end
`ifdef RESET_SEQUENCER_PFAIL_EN
      S_PFAIL: begin
        cause_d = cause_q | active_vec;
        if (pcnt_q == PFAIL_LAST) begin
          state_d = S_HOLD;
          hcnt_d  = '0;
          dclo_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
`endif
      S_HOLD: begin
        cause_d = cause_q | active_vec;
        if (!active) begin
          state_d = S_DCLO;
          dcnt_d  = '0;
          cold_d  = (hcnt_q == HOLD_MAX);
        end else if (hcnt_q != HOLD_MAX) begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      S_DCLO: begin
        if (active) begin
          state_d = S_HOLD;
          hcnt_d  = '0;
          dclo_d  = 1'b1;
          aclo_d  = 1'b1;
          cause_d = cause_q | active_vec;
        end else if (dcnt_q == DCLO_LAST) begin
          state_d = S_ACLO;
          acnt_d  = '0;
          dclo_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_ACLO: begin
        // A new request during release goes straight back to HOLD, skipping the lead phase.
        if (active) begin
          state_d = S_HOLD;
          hcnt_d  = '0;
          dclo_d  = 1'b1;
          aclo_d  = 1'b1;
          cause_d = cause_q | active_vec;
        end else if (acnt_q == ACLO_LAST) begin
          state_d = S_RUN;
          aclo_d  = 1'b0;
        end else begin
          acnt_d = acnt_q + AW'(1);
        end
      end
      default: begin
        state_d = S_DCLO;
        dcnt_d  = '0;
        dclo_d  = 1'b1;
        aclo_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DCLO;
      dclo_q  <= 1'b1;
      aclo_q  <= 1'b1;
      busy_q  <= 1'b1;
      cold_q  <= 1'b1;
      cause_q <= '0;
      dcnt_q  <= '0;
      acnt_q  <= '0;
      hcnt_q  <= '0;
`ifdef RESET_SEQUENCER_PFAIL_EN
      pcnt_q  <= '0;
`endif
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dclo_q  <= dclo_d;
      aclo_q  <= aclo_d;
      busy_q  <= busy_d;
      cold_q  <= cold_d;
      cause_q <= cause_d;
      dcnt_q  <= dcnt_d;
      acnt_q  <= acnt_d;
      hcnt_q  <= hcnt_d;
`ifdef RESET_SEQUENCER_PFAIL_EN
      pcnt_q  <= pcnt_d;
`endif
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign dclo       = dclo_q;
  assign aclo       = aclo_q;
  assign busy       = busy_q;
  assign cold_start = cold_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Expectations follow RESET_SEQUENCER_PFAIL_EN when it is defined for the build.
module tb_reset_sequencer;

`ifdef RESET_SEQUENCER_PFAIL_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] req_mask;
  logic       dclo;
  logic       aclo;
  logic       cold_start;
  logic [3:0] cause;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  reset_sequencer #(
    .N_SRC      (4),
    .DCLO_CLK   (4),
    .ACLO_CLK   (10),
    .PFAIL_CLK  (3),
    .COLD_CLK   (20),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_mask  (req_mask),
    .dclo      (dclo),
    .aclo      (aclo),
    .cold_start(cold_start),
    .cause     (cause),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lead = cycles until the sequencer sits in DCLO with its counter at zero.
  task automatic expect_release(input string tag, input int lead);
    repeat (lead) tick();
    repeat (3) tick();
    check({tag, "_dclo_held"}, 32'(dclo), 32'd1);
    tick();
    check({tag, "_dclo_fall"}, 32'(dclo), 32'd0);
    check({tag, "_aclo_on"},   32'(aclo), 32'd1);
    repeat (9) tick();
    check({tag, "_aclo_held"}, 32'(aclo), 32'd1);
    tick();
    check({tag, "_aclo_fall"}, 32'(aclo), 32'd0);
    check({tag, "_idle"},      32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0000;
    req_mask = 4'b0000;
    repeat (3) tick();
    check("rst_dclo",  32'(dclo),       32'd1);
    check("rst_aclo",  32'(aclo),       32'd1);
    check("rst_busy",  32'(busy),       32'd1);
    check("rst_cold",  32'(cold_start), 32'd1);
    check("rst_cause", 32'(cause),      32'd0);

    reset = 1'b0;
    expect_release("boot", 0);
    check("boot_cold",  32'(cold_start), 32'd1);
    check("boot_cause", 32'(cause),      32'd0);

    req = 4'b0010;
    repeat (2) tick();
    check("s2_aclo_pre", 32'(aclo), 32'd0);
    tick();
    check("s2_aclo_e3", 32'(aclo), 32'd1);
    check("s2_dclo_e3", 32'(dclo), 32'(!PF));
    repeat (2) tick();
    check("s2_dclo_e5", 32'(dclo), 32'(!PF));
    tick();
    check("s2_dclo_e6", 32'(dclo), 32'd1);
    repeat (2) tick();
    req = 4'b0000;
    expect_release("s2", 3);
    check("s2_cause", 32'(cause),      32'b0010);
    check("s2_cold",  32'(cold_start), 32'd0);

    req = 4'b0001;
    repeat (40) tick();
    req = 4'b0000;
    expect_release("long", 3);
    check("long_cold",  32'(cold_start), 32'd1);
    check("long_cause", 32'(cause),      32'b0001);

    req = 4'b0001;
    repeat (5) tick();
    req = 4'b0000;
    expect_release("short", 3);
    check("short_cold", 32'(cold_start), 32'd0);

    req = 4'b0010;
    repeat (5) tick();
    req = 4'b0000;
    repeat (11) tick();
    check("re_in_aclo_d", 32'(dclo), 32'd0);
    check("re_in_aclo_a", 32'(aclo), 32'd1);
    req = 4'b1000;
    repeat (2) tick();
    check("re_dclo_pre", 32'(dclo), 32'd0);
    tick();
    check("re_dclo_back", 32'(dclo),  32'd1);
    check("re_aclo_back", 32'(aclo),  32'd1);
    check("re_cause_or",  32'(cause), 32'b1010);
    req = 4'b0000;
    expect_release("re", 3);
    check("re_cause", 32'(cause), 32'b1010);

    req_mask = 4'b0001;
    req      = 4'b0001;
    repeat (6) tick();
    check("mask_busy", 32'(busy), 32'd0);
    check("mask_aclo", 32'(aclo), 32'd0);
    check("mask_dclo", 32'(dclo), 32'd0);
    req_mask = 4'b0000;
    tick();
    check("unmask_aclo", 32'(aclo), 32'd1);
    check("unmask_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    req = 4'b0000;
    expect_release("unmask", 3);
    check("unmask_cause", 32'(cause), 32'b0001);

    req = 4'b0101;
    repeat (8) tick();
    req_mask = 4'b0101;
    expect_release("midmask", 1);
    check("midmask_cause", 32'(cause), 32'b0101);
    req = 4'b0000;
    repeat (3) tick();
    req_mask = 4'b0000;
    repeat (3) tick();
    check("midmask_idle", 32'(busy), 32'd0);

    req = 4'b0100;
    repeat (2) tick();
    check("hr_aclo_pre", 32'(aclo), 32'd0);
    check("hr_dclo_pre", 32'(dclo), 32'd0);
    tick();
    check("hr_aclo_e3", 32'(aclo), 32'd1);
    check("hr_dclo_e3", 32'(dclo), 32'(!PF));
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("hr_rst_dclo",  32'(dclo),       32'd1);
    check("hr_rst_aclo",  32'(aclo),       32'd1);
    check("hr_rst_cause", 32'(cause),      32'd0);
    check("hr_rst_cold",  32'(cold_start), 32'd1);
    check("hr_rst_busy",  32'(busy),       32'd1);
    req   = 4'b0000;
    reset = 1'b0;
    expect_release("hr", 0);
    check("hr_cause", 32'(cause), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
